// File: rtl/gpio_pin_sync_pcint.sv
// gpio_pin_sync_pcint
//   Input front end for GPIO ports B, C and D. Raw pad levels are brought into
//   the clk domain through a SYNC_STAGES-deep flop chain per pin. The
//   synchronised levels feed the gpio block's pin inputs. Pin changes raise
//   ATmega328P-style pin-change interrupts through a PCICR / PCIFR / PCMSK0..2
//   register set on the shared memory bus.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb  bus request (wstrb == 0 means read)
//   mem_rdata                combinational read data (selected register or 0)
//   mem_ready                registered acknowledge, mapped addresses only
//   pad_in_b/c/d             raw asynchronous pad inputs
//   pin_sync_b/c/d           synchronised pin levels
//   irq_ack[2:0]             per-group flag clear from the interrupt controller
//   pcint_irq[2:0]           per-group level interrupt (flag & enable)
//
// Register map (relative to BASE_ADDR, data in bits [7:0])
//   +0x00 PCICR  [2:0] group enable
//   +0x04 PCIFR  [2:0] group flag, write-1-to-clear
//   +0x08 PCMSK0 port B mask, +0x0C PCMSK1 port C mask, +0x10 PCMSK2 port D mask
//
// SYNC_STAGES is intended to be 2 or 3.
module gpio_pin_sync_pcint #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic [7:0]  pad_in_b,
  input  logic [7:0]  pad_in_c,
  input  logic [7:0]  pad_in_d,
  output logic [7:0]  pin_sync_b,
  output logic [7:0]  pin_sync_c,
  output logic [7:0]  pin_sync_d,
  input  logic [2:0]  irq_ack,
  output logic [2:0]  pcint_irq
);

  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);

  // Registers
  logic [2:0]       r_pcicr;
  logic [2:0]       r_pcifr;
  logic [2:0][7:0]  r_pcmsk;   // [0]=B, [1]=C, [2]=D

  // Pins are handled as one 24-bit vector {D, C, B}
  logic [SYNC_STAGES-1:0][23:0] r_sync;
  logic [23:0]                  r_prev;
  logic [2:0]                   r_settle;

  logic [23:0] w_pad;
  logic [23:0] w_pin;
  logic        w_settled;
  logic [2:0]  w_chg;
  logic [2:0]  w_set;
  logic [2:0]  w_clr;

  logic w_sel_cr, w_sel_fr, w_sel_m0, w_sel_m1, w_sel_m2, w_sel, w_wr;
  logic w_unused_bits;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign w_sel_cr = (mem_addr == BASE_ADDR);
  assign w_sel_fr = (mem_addr == BASE_ADDR + 32'h04);
  assign w_sel_m0 = (mem_addr == BASE_ADDR + 32'h08);
  assign w_sel_m1 = (mem_addr == BASE_ADDR + 32'h0C);
  assign w_sel_m2 = (mem_addr == BASE_ADDR + 32'h10);
  assign w_sel    = w_sel_cr | w_sel_fr | w_sel_m0 | w_sel_m1 | w_sel_m2;
  // Only byte lane 0 carries register data; the other strobes are don't-care.
  assign w_wr     = mem_valid & w_sel & mem_wstrb[0];

  assign w_unused_bits = &{1'b0, mem_wdata[31:8], mem_wstrb[3:1]};

  always_comb begin
    mem_rdata = '0;
    if (w_sel_cr) mem_rdata[2:0] = r_pcicr;
    if (w_sel_fr) mem_rdata[2:0] = r_pcifr;
    if (w_sel_m0) mem_rdata[7:0] = r_pcmsk[0];
    if (w_sel_m1) mem_rdata[7:0] = r_pcmsk[1];
    if (w_sel_m2) mem_rdata[7:0] = r_pcmsk[2];
  end

  // ---------------------------------------------------------------------------
  // Synchroniser and change detection
  // ---------------------------------------------------------------------------
  assign w_pad = {pad_in_d, pad_in_c, pad_in_b};
  assign w_pin = r_sync[SYNC_STAGES-1];

  assign pin_sync_b = w_pin[7:0];
  assign pin_sync_c = w_pin[15:8];
  assign pin_sync_d = w_pin[23:16];

  // After reset the chain is all-zero while pads may already be high; the
  // resulting first "edge" is ignored until the counter saturates.
  assign w_settled = (r_settle == SETTLE_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_grp
      assign w_chg[gi] = |((w_pin[gi*8 +: 8] ^ r_prev[gi*8 +: 8]) & r_pcmsk[gi]);
    end
  endgenerate

  assign w_set = w_chg & {3{w_settled}};
  assign w_clr = ((w_wr & w_sel_fr) ? mem_wdata[2:0] : 3'b000) | irq_ack;

  assign pcint_irq = r_pcifr & r_pcicr;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_prev    <= '0;
      r_settle  <= '0;
      r_pcicr   <= '0;
      r_pcifr   <= '0;
      r_pcmsk   <= '0;
      mem_ready <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad};
      end else begin
        r_sync <= w_pad;
      end
      r_prev <= w_pin;

      if (!w_settled) begin
        r_settle <= r_settle + 3'd1;
      end

      mem_ready <= mem_valid & w_sel;

      if (w_wr & w_sel_cr) r_pcicr    <= mem_wdata[2:0];
      if (w_wr & w_sel_m0) r_pcmsk[0] <= mem_wdata[7:0];
      if (w_wr & w_sel_m1) r_pcmsk[1] <= mem_wdata[7:0];
      if (w_wr & w_sel_m2) r_pcmsk[2] <= mem_wdata[7:0];

      // A new change wins over a clear in the same cycle.
      r_pcifr <= (r_pcifr & ~w_clr) | w_set;
    end
  end

endmodule

// File: tb/tb_gpio_pin_sync_pcint.sv
// Directed testbench for gpio_pin_sync_pcint (SYNC_STAGES = 2).
module tb_gpio_pin_sync_pcint;

  localparam logic [31:0] BASE   = 32'h1000_0100;
  localparam logic [31:0] A_CR   = BASE;
  localparam logic [31:0] A_FR   = BASE + 32'h04;
  localparam logic [31:0] A_M0   = BASE + 32'h08;
  localparam logic [31:0] A_M1   = BASE + 32'h0C;
  localparam logic [31:0] A_M2   = BASE + 32'h10;
  localparam logic [31:0] A_BAD  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [7:0]  pad_in_b, pad_in_c, pad_in_d;
  logic [7:0]  pin_sync_b, pin_sync_c, pin_sync_d;
  logic [2:0]  irq_ack;
  logic [2:0]  pcint_irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_pin_sync_pcint #(.SYNC_STAGES(2), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pad_in_b(pad_in_b), .pad_in_c(pad_in_c), .pad_in_d(pad_in_d),
    .pin_sync_b(pin_sync_b), .pin_sync_c(pin_sync_c), .pin_sync_d(pin_sync_d),
    .irq_ack(irq_ack), .pcint_irq(pcint_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = data; mem_wstrb = 4'b0001;
    tick();
    mem_valid = 1'b0; mem_wstrb = 4'b0000;
  endtask

  // Combinational read with no clock edge in between.
  task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    mem_valid = 1'b1; mem_addr = addr; mem_wstrb = 4'b0000;
    #1;
    check(tag, mem_rdata, exp);
    mem_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    pad_in_b = 8'hFF; pad_in_c = 8'h00; pad_in_d = 8'h00; irq_ack = 3'b000;

    // Reset state
    repeat (3) tick();
    check("rst_pin_b", {24'h0, pin_sync_b}, 32'h0);
    check("rst_irq",   {29'h0, pcint_irq}, 32'h0);
    check("rst_ready", {31'h0, mem_ready}, 32'h0);
    rst = 1'b0;

    // High pads at reset must not flag even with mask written at cycle 1
    bus_write(A_M0, 32'hFF);
    repeat (4) tick();
    check("settle_pin_b", {24'h0, pin_sync_b}, 32'hFF);
    peek("settle_pcifr", A_FR, 32'h00);
    peek("pcmsk0", A_M0, 32'hFF);

    // Port D edge: latency and flag timing
    bus_write(A_M2, 32'h10);
    pad_in_d = 8'h10;
    tick();
    check("d_lat1", {24'h0, pin_sync_d}, 32'h00);
    tick();
    check("d_lat2", {24'h0, pin_sync_d}, 32'h10);
    peek("d_flag_early", A_FR, 32'h00);
    tick();
    peek("d_flag", A_FR, 32'h04);
    check("d_irq_disabled", {29'h0, pcint_irq}, 32'h0);
    bus_write(A_CR, 32'h04);
    check("d_irq", {29'h0, pcint_irq}, 32'h4);

    // Clear all, then an unmasked port C toggle
    bus_write(A_FR, 32'h07);
    peek("w1c_all", A_FR, 32'h00);
    check("irq_clr", {29'h0, pcint_irq}, 32'h0);
    bus_write(A_M1, 32'h01);
    pad_in_c = 8'h02;
    repeat (3) tick();
    check("c_pin", {24'h0, pin_sync_c}, 32'h02);
    peek("c_unmasked", A_FR, 32'h00);

    // Set all three flags, partial W1C, then irq_ack
    pad_in_b = 8'hFE; pad_in_c = 8'h03; pad_in_d = 8'h00;
    repeat (3) tick();
    peek("all_flags", A_FR, 32'h07);
    check("all_irq", {29'h0, pcint_irq}, 32'h4);
    bus_write(A_FR, 32'h02);
    peek("w1c_bit1", A_FR, 32'h05);
    irq_ack = 3'b001;
    tick();
    irq_ack = 3'b000;
    peek("irq_ack_b", A_FR, 32'h04);

    // W1C of bit0 in the same cycle a port B flag sets: set wins
    pad_in_b = 8'hFF;
    tick();
    tick();
    bus_write(A_FR, 32'h01);
    peek("set_wins", A_FR, 32'h05);
    bus_write(A_FR, 32'h01);
    peek("w1c_bit0", A_FR, 32'h04);

    // Mask written in the same cycle as a change: old mask used
    pad_in_c = 8'h01;
    tick();
    tick();
    bus_write(A_M1, 32'h02);
    peek("old_mask", A_FR, 32'h04);
    peek("pcmsk1", A_M1, 32'h02);
    pad_in_c = 8'h03;
    repeat (3) tick();
    peek("new_mask", A_FR, 32'h06);

    // PCICR upper bits read 0; irq follows flag & enable
    bus_write(A_CR, 32'hFF);
    peek("pcicr_trunc", A_CR, 32'h07);
    check("irq_110", {29'h0, pcint_irq}, 32'h6);
    bus_write(A_CR, 32'h05);
    check("irq_100", {29'h0, pcint_irq}, 32'h4);

    // Read handshake on a mapped address
    tick();
    mem_valid = 1'b1; mem_addr = A_CR; mem_wstrb = 4'b0000;
    #1;
    check("rd_cr_data", mem_rdata, 32'h5);
    check("rd_ready_pre", {31'h0, mem_ready}, 32'h0);
    tick();
    check("rd_ready", {31'h0, mem_ready}, 32'h1);
    mem_valid = 1'b0;
    tick();
    check("rd_ready_drop", {31'h0, mem_ready}, 32'h0);

    // Unmapped address: no ack, rdata 0, no write
    mem_valid = 1'b1; mem_addr = A_BAD; mem_wdata = 32'hFF; mem_wstrb = 4'b0001;
    #1;
    check("bad_rdata", mem_rdata, 32'h0);
    tick();
    check("bad_ready", {31'h0, mem_ready}, 32'h0);
    mem_valid = 1'b0; mem_wstrb = 4'b0000;
    peek("bad_nowrite", A_CR, 32'h05);

    // Lane 0 strobe clear: write ignored
    mem_valid = 1'b1; mem_addr = A_M0; mem_wdata = 32'h00; mem_wstrb = 4'b1110;
    tick();
    mem_valid = 1'b0; mem_wstrb = 4'b0000;
    peek("strobe_ignored", A_M0, 32'hFF);

    // Mid-operation reset
    rst = 1'b1;
    tick();
    peek("mrst_pcicr", A_CR, 32'h0);
    peek("mrst_pcifr", A_FR, 32'h0);
    peek("mrst_pcmsk0", A_M0, 32'h0);
    check("mrst_irq", {29'h0, pcint_irq}, 32'h0);
    check("mrst_pin_b", {24'h0, pin_sync_b}, 32'h0);
    check("mrst_ready", {31'h0, mem_ready}, 32'h0);
    rst = 1'b0;
    bus_write(A_M0, 32'hFF);
    bus_write(A_M1, 32'hFF);
    repeat (5) tick();
    peek("mrst_settle", A_FR, 32'h00);
    check("mrst_pin_c", {24'h0, pin_sync_c}, 32'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
